// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM states,
// default operand width and the counter-width helper.
package mult_pkg;

  localparam int MULT_N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// N-bit carry-lookahead adder: every carry is formed directly from the
// generate/propagate terms and cin rather than rippling.
module carry_lookahead_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] gen;
  logic [N-1:0] prp;
  logic [N:0]   c;
  logic         term;
  logic         chain;

  assign gen = a & b;
  assign prp = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, fully expanded
  always_comb begin
    c     = '0;
    term  = 1'b0;
    chain = 1'b0;
    c[0]  = cin;
    for (int i = 0; i < N; i++) begin
      term  = gen[i];
      chain = prp[i];
      for (int j = i - 1; j >= 0; j--) begin
        term  = term | (chain & gen[j]);
        chain = chain & prp[j];
      end
      c[i+1] = term | (chain & cin);
    end
  end

  assign sum  = prp ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N shift-add multiplier with valid/ready
// handshakes on both sides. One partial-product step per RUN cycle.
// Optional feature: define MULT_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero (latency = msb index of b + 1).
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int N = MULT_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int CW = clog2(N);

  state_t         state, state_nx;
  logic [2*N-1:0] p;        // {accumulator, unconsumed multiplier bits}
  logic [2*N-1:0] p_step;   // P after one add-and-shift
  logic [2*N-1:0] p_run;    // value loaded into P this RUN cycle
  logic [N-1:0]   mcand;
  logic [N-1:0]   addend;
  logic [N-1:0]   sum;
  logic           cout;
  logic [CW-1:0]  cnt;
  logic           last;

  // Multiplicand is gated by the current multiplier bit.
  assign addend = mcand & {N{p[0]}};

  carry_lookahead_adder #(.N(N)) u_cla (
    .a    (p[2*N-1:N]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign p_step = {cout, sum, p[N-1:1]};

`ifdef MULT_EARLY_EXIT_EN
  logic [N-1:0] rem_mask;

  // Stop once the multiplier bits left after this step are zero; the
  // skipped steps would only add zero and shift, so shift them in one go.
  always_comb begin
    rem_mask = {N{1'b1}} >> (32'(cnt) + 32'd1);
    last     = ((p[N-1:0] >> 1) & rem_mask) == '0;
    p_run    = p_step >> (32'(N - 1) - 32'(cnt));
  end
`else
  // Fixed latency: exactly N steps.
  always_comb begin
    last  = (cnt == CW'(N - 1));
    p_run = p_step;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Datapath: load operands on accept, step P during RUN, hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p     <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand <= a;
          p     <= {{N{1'b0}}, b};
          cnt   <= '0;
        end
        RUN: begin
          p   <= p_run;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = p;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (N=4): the driver pushes the
// arithmetic expectation on every accept, a negedge monitor checks latency,
// product stability and the single result per operation.
module tb_shift_add_multiplier;

  localparam int N = 4;

  typedef struct {
    logic [2*N-1:0] prod;
    int             acc;
    int             lat;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic           busy;

  int   nvec;
  int   nerr;
  int   cyc;
  bit   started;
  bit   seen;
  exp_t q[$];

  shift_add_multiplier #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: plain multiplication; latency from the position of b's msb.
  function automatic int model_lat(input logic [N-1:0] bb);
    int l;
`ifdef MULT_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < N; i++) if (bb[i]) l = i + 1;
`else
    l = N;
`endif
    return l;
  endfunction

  task automatic push_exp(input logic [N-1:0] aa, input logic [N-1:0] bb);
    exp_t e;
    e.prod = (2*N)'(int'(aa) * int'(bb));
    e.acc  = cyc + 1;
    e.lat  = model_lat(bb);
    q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a result
  always @(negedge clk) begin
    if (started && rst_n) begin
      chk("in_ready_vs_busy", 64'(in_ready), 64'(!busy));
      if (out_valid) begin
        chk("out_valid_busy", 64'(busy), 64'd1);
        if (q.size() == 0) begin
          fail_now("extra_result");
        end else begin
          if (!seen) begin
            chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
            seen = 1'b1;
          end
          chk("product", 64'(product), 64'(q[0].prod));
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Present one operand pair once the DUT is ready (called at posedge+1)
  task automatic do_op(input logic [N-1:0] aa, input logic [N-1:0] bb);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) fail_now("in_ready_timeout");
    in_valid = 1'b1;
    a        = aa;
    b        = bb;
    push_exp(aa, bb);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (q.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    logic [N-1:0] dir_a [7];
    logic [N-1:0] dir_b [7];
    int w;
    int nacc;

    nvec = 0; nerr = 0; cyc = 0; started = 1'b0; seen = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_product", 64'(product), 64'd0);
    started = 1'b1;

    // Directed pairs, including full-scale and zero operands
    dir_a = '{4'd13, 4'd15, 4'd0, 4'd9, 4'd3, 4'd3, 4'd3};
    dir_b = '{4'd11, 4'd15, 4'd9, 4'd0, 4'd1, 4'd4, 4'd8};
    for (int i = 0; i < 7; i++) begin
      do_op(dir_a[i], dir_b[i]);
      wait_drain();
      chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
    end

    // Back-pressure: result must hold while new requests are ignored
    out_ready = 1'b0;
    do_op(4'd7, 4'd6);
    w = 0;
    while (!out_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!out_valid) fail_now("stall_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 4'($urandom);
      b = 4'($urandom);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_product", 64'(product), 64'h2A);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("stall_release_idle", 64'(in_ready), 64'd1);

    // Reset during the second RUN cycle discards the operation
    do_op(4'd5, 4'd12);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    seen = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_product", 64'(product), 64'd0);
    do_op(4'd3, 4'd5);
    wait_drain();

    // Random back-to-back traffic with random consumer back-pressure
    nacc = 0;
    w    = 0;
    while (nacc < 1000 && w < 40000) begin
      in_valid  = 1'b1;
      a         = 4'($urandom);
      b         = 4'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      if (in_ready) begin
        push_exp(a, b);
        nacc++;
      end
      @(posedge clk); #1;
      w++;
    end
    if (nacc < 1000) fail_now("random_accept_timeout");
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    chk("no_leftover_results", 64'(q.size()), 64'd0);
    chk("final_idle", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
